// File: rtl/coco_tc_pkg.sv
// Shared types and constants for the Coco timer/counter access controller.
package coco_tc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } tc_state_e;

   localparam logic [1:0] TC_CTRL   = 2'd0;
   localparam logic [1:0] TC_PRESET = 2'd1;
   localparam logic [1:0] TC_COUNT  = 2'd2;

   localparam int CTRL_IM_BIT   = 0;
   localparam int CTRL_MODE_LSB = 1;
   localparam int CTRL_MODE_MSB = 2;

   typedef logic req_id_t;

   function automatic logic addr_legal(input logic [1:0] add, input int unsigned nreg);
      return 32'(add) < nreg;
   endfunction

endpackage

// File: rtl/coco_tc_if.sv
// Requester bus, timer register port and interrupt lines of the TC controller.
interface coco_tc_if;
   logic        Req0, Req1;
   logic        We0, We1;
   logic [1:0]  Add0, Add1;
   logic [31:0] Wdata0, Wdata1;
   logic        Gnt0, Gnt1;
   logic        Done0, Done1;
   logic        Err0, Err1;
   logic [31:0] Rdata;
   logic [1:0]  Tc_Add;
   logic        Tc_We;
   logic [31:0] Tc_Data_In;
   logic [31:0] Tc_Data_Out;
   logic        Tc_Out;
   logic        Irq;
   logic        Irq_Ack;
   logic        Irq_Lost;

   // slave: the controller, serving requesters and driving the timer port
   modport slave (
      input  Req0, Req1, We0, We1, Add0, Add1, Wdata0, Wdata1,
      input  Tc_Data_Out, Tc_Out, Irq_Ack,
      output Gnt0, Gnt1, Done0, Done1, Err0, Err1, Rdata,
      output Tc_Add, Tc_We, Tc_Data_In, Irq, Irq_Lost
   );

   // master: the requesters together with the timer instance
   modport master (
      output Req0, Req1, We0, We1, Add0, Add1, Wdata0, Wdata1,
      output Tc_Data_Out, Tc_Out, Irq_Ack,
      input  Gnt0, Gnt1, Done0, Done1, Err0, Err1, Rdata,
      input  Tc_Add, Tc_We, Tc_Data_In, Irq, Irq_Lost
   );
endinterface

// File: rtl/coco_tc_irq.sv
// Turns the timer's level Out into a latched, acknowledgeable interrupt with loss flag.
module coco_tc_irq (
   input  logic Clk,
   input  logic Reset,
   input  logic Tc_Out_i,
   input  logic Irq_Ack_i,
   output logic Irq_o,
   output logic Irq_Lost_o
);

   logic out_q;
   logic irq_q, irq_d;
   logic lost_q, lost_d;
   logic rise;

   assign rise = Tc_Out_i & ~out_q;

   // a new edge beats a concurrent ack; the ack still suppresses the loss record
   always_comb begin
      irq_d  = irq_q;
      lost_d = lost_q;
      if (rise)
         irq_d = 1'b1;
      else if (Irq_Ack_i)
         irq_d = 1'b0;
      if (Irq_Ack_i)
         lost_d = 1'b0;
      else if (rise && irq_q)
         lost_d = 1'b1;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         out_q  <= 1'b1;
         irq_q  <= 1'b0;
         lost_q <= 1'b0;
      end else begin
         out_q  <= Tc_Out_i;
         irq_q  <= irq_d;
         lost_q <= lost_d;
      end
   end

   assign Irq_o      = irq_q;
   assign Irq_Lost_o = lost_q;

endmodule

// File: rtl/coco_tc_ctrl.sv
// Round-robin arbiter and access FSM for the Coco TC register port.
//   state     | meaning
//   ST_IDLE   | waiting for a request; picks a winner and latches its transaction
//   ST_ACCESS | winner owns the timer port; write strobe or read capture
//   ST_RESP   | Done/Err pulse to the winner; last-served pointer updated
module coco_tc_ctrl
   import coco_tc_pkg::*;
#(
   parameter int unsigned NREG = 3
) (
   input  logic      Clk,
   input  logic      Reset,
   coco_tc_if.slave  bus
);

   tc_state_e   state_q, state_d;
   req_id_t     id_q, id_d;
   req_id_t     last_q, last_d;
   logic        we_q, we_d;
   logic [1:0]  add_q, add_d;
   logic [31:0] wdata_q, wdata_d;
   logic        err_q, err_d;
   logic [31:0] rdata_q, rdata_d;

   req_id_t     win;
   logic        legal;
   logic        gnt0, gnt1, done0, done1, err0, err1, tc_we;
   logic [1:0]  tc_add;
   logic [31:0] tc_data_in;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         id_q    <= 1'b0;
         last_q  <= 1'b1;
         we_q    <= 1'b0;
         add_q   <= 2'd0;
         wdata_q <= 32'd0;
         err_q   <= 1'b0;
         rdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         last_q  <= last_d;
         we_q    <= we_d;
         add_q   <= add_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   // under contention the requester not served last wins
   assign win   = bus.Req0 ? (bus.Req1 ? ~last_q : 1'b0) : 1'b1;
   assign legal = addr_legal(add_q, NREG);

   always_comb begin
      state_d    = state_q;
      id_d       = id_q;
      last_d     = last_q;
      we_d       = we_q;
      add_d      = add_q;
      wdata_d    = wdata_q;
      err_d      = err_q;
      rdata_d    = rdata_q;
      gnt0       = 1'b0;
      gnt1       = 1'b0;
      done0      = 1'b0;
      done1      = 1'b0;
      err0       = 1'b0;
      err1       = 1'b0;
      tc_we      = 1'b0;
      tc_add     = 2'd0;
      tc_data_in = 32'd0;
      case (state_q)
         ST_IDLE: begin
            if (bus.Req0 || bus.Req1) begin
               id_d    = win;
               we_d    = win ? bus.We1    : bus.We0;
               add_d   = win ? bus.Add1   : bus.Add0;
               wdata_d = win ? bus.Wdata1 : bus.Wdata0;
               state_d = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            gnt0   = (id_q == 1'b0);
            gnt1   = (id_q == 1'b1);
            tc_add = add_q;
            err_d  = ~legal;
            if (!legal) begin
               rdata_d = 32'd0;
            end else if (we_q) begin
               tc_we      = 1'b1;
               tc_data_in = wdata_q;
            end else begin
               rdata_d = bus.Tc_Data_Out;
            end
            state_d = ST_RESP;
         end
         ST_RESP: begin
            done0   = (id_q == 1'b0);
            done1   = (id_q == 1'b1);
            err0    = (id_q == 1'b0) & err_q;
            err1    = (id_q == 1'b1) & err_q;
            last_d  = id_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // reset is synchronous, so the current-state decode must be masked in the reset cycle itself
      if (Reset) begin
         gnt0  = 1'b0;
         gnt1  = 1'b0;
         done0 = 1'b0;
         done1 = 1'b0;
         err0  = 1'b0;
         err1  = 1'b0;
         tc_we = 1'b0;
      end
   end

   assign bus.Gnt0       = gnt0;
   assign bus.Gnt1       = gnt1;
   assign bus.Done0      = done0;
   assign bus.Done1      = done1;
   assign bus.Err0       = err0;
   assign bus.Err1       = err1;
   assign bus.Rdata      = rdata_q;
   assign bus.Tc_We      = tc_we;
   assign bus.Tc_Add     = tc_add;
   assign bus.Tc_Data_In = tc_data_in;

   coco_tc_irq u_irq (
      .Clk        (Clk),
      .Reset      (Reset),
      .Tc_Out_i   (bus.Tc_Out),
      .Irq_Ack_i  (bus.Irq_Ack),
      .Irq_o      (bus.Irq),
      .Irq_Lost_o (bus.Irq_Lost)
   );

endmodule

// File: tb/tb_coco_tc_ctrl.sv
// Directed bench for coco_tc_ctrl: writes, reads, contention, illegal address, interrupt, reset.
module tb_coco_tc_ctrl;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   coco_tc_if bus ();

   coco_tc_ctrl #(.NREG(3)) dut (
      .Clk   (clk),
      .Reset (rst),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      bus.Req0 = 0; bus.Req1 = 0; bus.We0 = 0; bus.We1 = 0;
      bus.Add0 = 0; bus.Add1 = 0; bus.Wdata0 = 0; bus.Wdata1 = 0;
      bus.Tc_Data_Out = 0; bus.Tc_Out = 0; bus.Irq_Ack = 0;
      step(); step();
      rst = 1'b0;

      chk("rst_gnt",   {30'd0, bus.Gnt1, bus.Gnt0}, 32'd0);
      chk("rst_done",  {30'd0, bus.Done1, bus.Done0}, 32'd0);
      chk("rst_err",   {30'd0, bus.Err1, bus.Err0}, 32'd0);
      chk("rst_rdata", bus.Rdata, 32'd0);
      chk("rst_tcwe",  {31'd0, bus.Tc_We}, 32'd0);
      chk("rst_tcadd", {30'd0, bus.Tc_Add}, 32'd0);
      chk("rst_tcdin", bus.Tc_Data_In, 32'd0);
      chk("rst_irq",   {30'd0, bus.Irq_Lost, bus.Irq}, 32'd0);

      // single write
      bus.Req0 = 1; bus.We0 = 1; bus.Add0 = 2'd1; bus.Wdata0 = 32'd10;
      step();
      chk("wr_gnt0",  {31'd0, bus.Gnt0}, 32'd1);
      chk("wr_tcwe",  {31'd0, bus.Tc_We}, 32'd1);
      chk("wr_tcadd", {30'd0, bus.Tc_Add}, 32'd1);
      chk("wr_tcdin", bus.Tc_Data_In, 32'd10);
      chk("wr_done_early", {31'd0, bus.Done0}, 32'd0);
      step();
      chk("wr_done0", {31'd0, bus.Done0}, 32'd1);
      chk("wr_err0",  {31'd0, bus.Err0}, 32'd0);
      chk("wr_tcwe_off", {31'd0, bus.Tc_We}, 32'd0);
      chk("wr_rdata_keep", bus.Rdata, 32'd0);
      bus.Req0 = 0;
      step();
      chk("wr_idle_done", {31'd0, bus.Done0}, 32'd0);
      chk("wr_idle_tcwe", {31'd0, bus.Tc_We}, 32'd0);

      // read from requester 1
      bus.Req1 = 1; bus.We1 = 0; bus.Add1 = 2'd2; bus.Tc_Data_Out = 32'h1234;
      step();
      chk("rd_gnt1",  {31'd0, bus.Gnt1}, 32'd1);
      chk("rd_tcwe",  {31'd0, bus.Tc_We}, 32'd0);
      chk("rd_tcadd", {30'd0, bus.Tc_Add}, 32'd2);
      step();
      chk("rd_done1", {31'd0, bus.Done1}, 32'd1);
      chk("rd_err1",  {31'd0, bus.Err1}, 32'd0);
      chk("rd_rdata", bus.Rdata, 32'h1234);
      bus.Req1 = 0; bus.Tc_Data_Out = 32'hdead;
      step();
      chk("rd_rdata_hold", bus.Rdata, 32'h1234);

      // contention from reset: grants alternate 0,1,0,1
      rst = 1'b1;
      step();
      rst = 1'b0;
      bus.Req0 = 1; bus.We0 = 1; bus.Add0 = 2'd0; bus.Wdata0 = 32'haa;
      bus.Req1 = 1; bus.We1 = 0; bus.Add1 = 2'd1; bus.Tc_Data_Out = 32'h55;
      for (int k = 0; k < 4; k++) begin
         step();
         chk($sformatf("ct_gnt_%0d", k), {30'd0, bus.Gnt1, bus.Gnt0},
             (k % 2 == 0) ? 32'd1 : 32'd2);
         chk($sformatf("ct_tcwe_%0d", k), {31'd0, bus.Tc_We},
             (k % 2 == 0) ? 32'd1 : 32'd0);
         step();
         chk($sformatf("ct_done_%0d", k), {30'd0, bus.Done1, bus.Done0},
             (k % 2 == 0) ? 32'd1 : 32'd2);
         if (k == 3) begin
            bus.Req0 = 0;
            bus.Req1 = 0;
         end
         step();
         chk($sformatf("ct_idle_%0d", k), {28'd0, bus.Gnt1, bus.Gnt0, bus.Done1, bus.Done0}, 32'd0);
      end
      chk("ct_rdata", bus.Rdata, 32'h55);

      // illegal address
      bus.Req0 = 1; bus.We0 = 1; bus.Add0 = 2'd3; bus.Wdata0 = 32'hff;
      step();
      chk("il_gnt0", {31'd0, bus.Gnt0}, 32'd1);
      chk("il_tcwe", {31'd0, bus.Tc_We}, 32'd0);
      step();
      chk("il_done0", {31'd0, bus.Done0}, 32'd1);
      chk("il_err0",  {31'd0, bus.Err0}, 32'd1);
      chk("il_rdata", bus.Rdata, 32'd0);
      chk("il_tcwe2", {31'd0, bus.Tc_We}, 32'd0);
      bus.Req0 = 0;
      step();

      // interrupt edge, loss, ack, and edge coinciding with ack
      bus.Tc_Out = 1;
      step();
      chk("irq_set",  {30'd0, bus.Irq_Lost, bus.Irq}, 32'd1);
      bus.Tc_Out = 0;
      step();
      bus.Tc_Out = 1;
      step();
      chk("irq_lost", {30'd0, bus.Irq_Lost, bus.Irq}, 32'd3);
      bus.Tc_Out = 0; bus.Irq_Ack = 1;
      step();
      chk("irq_ack",  {30'd0, bus.Irq_Lost, bus.Irq}, 32'd0);
      bus.Irq_Ack = 0; bus.Tc_Out = 1;
      step();
      chk("irq_set2", {30'd0, bus.Irq_Lost, bus.Irq}, 32'd1);
      bus.Tc_Out = 0;
      step();
      bus.Tc_Out = 1;
      step();
      chk("irq_lost2", {30'd0, bus.Irq_Lost, bus.Irq}, 32'd3);
      bus.Tc_Out = 0;
      step();
      bus.Tc_Out = 1; bus.Irq_Ack = 1;
      step();
      chk("irq_edge_ack", {30'd0, bus.Irq_Lost, bus.Irq}, 32'd1);
      bus.Irq_Ack = 0;
      step();
      chk("irq_hold", {30'd0, bus.Irq_Lost, bus.Irq}, 32'd1);

      // reset while a write is in ACCESS
      bus.Req0 = 1; bus.We0 = 1; bus.Add0 = 2'd0; bus.Wdata0 = 32'd7;
      step();
      chk("rs_tcwe_pre", {31'd0, bus.Tc_We}, 32'd1);
      rst = 1'b1; bus.Req0 = 0;
      #1;
      chk("rs_tcwe_in", {31'd0, bus.Tc_We}, 32'd0);
      step();
      rst = 1'b0;
      chk("rs_done",  {31'd0, bus.Done0}, 32'd0);
      chk("rs_tcwe",  {31'd0, bus.Tc_We}, 32'd0);
      chk("rs_irq",   {30'd0, bus.Irq_Lost, bus.Irq}, 32'd0);
      step();
      chk("rs_done2", {31'd0, bus.Done0}, 32'd0);
      chk("rs_irq2",  {31'd0, bus.Irq}, 32'd0);

      // normal service after reset
      bus.Req0 = 1; bus.We0 = 1; bus.Add0 = 2'd2; bus.Wdata0 = 32'h99;
      step();
      chk("po_gnt0",  {31'd0, bus.Gnt0}, 32'd1);
      chk("po_tcwe",  {31'd0, bus.Tc_We}, 32'd1);
      chk("po_tcadd", {30'd0, bus.Tc_Add}, 32'd2);
      chk("po_tcdin", bus.Tc_Data_In, 32'h99);
      step();
      chk("po_done0", {31'd0, bus.Done0}, 32'd1);
      chk("po_err0",  {31'd0, bus.Err0}, 32'd0);
      bus.Req0 = 0;
      step();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
